// File: rtl/cve2_mem_arbiter_pkg.sv
// Shared types for the instr/data memory-port arbiter.
// Source tags identify which requester owns each outstanding memory transaction.
package cve2_mem_arbiter_pkg;

  typedef enum logic {
    MemSrcInstr = 1'b0,
    MemSrcData  = 1'b1
  } mem_src_e;

  localparam int unsigned MemArbMaxOutstanding = 4;

endpackage

// File: rtl/cve2_mem_arb_src_fifo.sv
// In-order FIFO of source tags for outstanding memory transactions.
// Latency: head valid the cycle after push; push ignored when full, pop ignored when empty.
module cve2_mem_arb_src_fifo
  import cve2_mem_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push,
  input  mem_src_e push_src,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output mem_src_e head
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  mem_src_e        mem_q [Depth];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic            push_en, pop_en;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= MemSrcInstr;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= push_src;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_en) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cve2_mem_arbiter.sv
// Shares one OBI memory port between instr fetch and LSU; responses routed back in order.
// Address phase is combinational; a pending ungranted request locks the source until granted.
module cve2_mem_arbiter
  import cve2_mem_arbiter_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          DataPriority   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        protocol_err_o
);

  localparam int unsigned FifoDepth =
      (MaxOutstanding == 0)                    ? 1 :
      (MaxOutstanding > MemArbMaxOutstanding)  ? MemArbMaxOutstanding : MaxOutstanding;

  logic     lock_q, protocol_err_q;
  mem_src_e lock_src_q, rr_last_q, sel, fifo_head;
  logic     sel_req, fifo_full, fifo_empty, handshake, resp_vld;

  always_comb begin
    sel = MemSrcInstr;
    if (lock_q) begin
      sel = lock_src_q;
    end else if (instr_req_i && data_req_i) begin
      if (DataPriority) sel = MemSrcData;
      else              sel = (rr_last_q == MemSrcData) ? MemSrcInstr : MemSrcData;
    end else if (data_req_i) begin
      sel = MemSrcData;
    end
  end

  // can_issue depends only on registered count, keeping rvalid off the req path
  assign sel_req   = (sel == MemSrcData) ? data_req_i : instr_req_i;
  assign mem_req_o = ~fifo_full & sel_req;
  assign handshake = mem_req_o & mem_gnt_i;

  assign mem_we_o    = (sel == MemSrcData) ? data_we_i    : 1'b0;
  assign mem_be_o    = (sel == MemSrcData) ? data_be_i    : 4'hF;
  assign mem_addr_o  = (sel == MemSrcData) ? data_addr_i  : instr_addr_i;
  assign mem_wdata_o = (sel == MemSrcData) ? data_wdata_i : 32'h0;

  assign instr_gnt_o = handshake & (sel == MemSrcInstr);
  assign data_gnt_o  = handshake & (sel == MemSrcData);

  assign resp_vld       = mem_rvalid_i & ~fifo_empty;
  assign instr_rvalid_o = resp_vld & (fifo_head == MemSrcInstr);
  assign data_rvalid_o  = resp_vld & (fifo_head == MemSrcData);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign instr_err_o    = mem_err_i;
  assign data_err_o     = mem_err_i;
  assign protocol_err_o = protocol_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q         <= 1'b0;
      lock_src_q     <= MemSrcInstr;
      rr_last_q      <= MemSrcData;
      protocol_err_q <= 1'b0;
    end else begin
      // a dropped req on the locked source simply lets the lock lapse
      lock_q <= mem_req_o & ~mem_gnt_i;
      if (mem_req_o && !mem_gnt_i) lock_src_q <= sel;
      if (handshake) rr_last_q <= sel;
      if (mem_rvalid_i && fifo_empty) protocol_err_q <= 1'b1;
    end
  end

  cve2_mem_arb_src_fifo #(
    .Depth (FifoDepth)
  ) u_src_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push     (handshake),
    .push_src (sel),
    .pop      (mem_rvalid_i),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

endmodule

// File: tb/tb_cve2_mem_arbiter.sv
// Directed and randomized checks of cve2_mem_arbiter in fixed-priority and round-robin builds.
module tb_cve2_mem_arbiter;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        instr_req, data_req, data_we, mem_gnt, mem_rvalid, mem_err;
  logic [31:0] instr_addr, data_addr, data_wdata, mem_rdata;
  logic [3:0]  data_be;
  bit          use_rr;
  int          n_assert = 0, n_fail = 0;

  logic        p_igused, p_ig, p_irv, p_ierr, p_dg, p_drv, p_derr, p_mreq, p_mwe, p_perr;
  logic [31:0] p_ird, p_drd, p_maddr, p_mwd;
  logic [3:0]  p_mbe;
  logic        r_ig, r_irv, r_ierr, r_dg, r_drv, r_derr, r_mreq, r_mwe, r_perr;
  logic [31:0] r_ird, r_drd, r_maddr, r_mwd;
  logic [3:0]  r_mbe;

  always #5 clk = ~clk;

  cve2_mem_arbiter #(.MaxOutstanding(2), .DataPriority(1'b1)) dut_p (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_gnt_o(p_ig), .instr_rvalid_o(p_irv), .instr_addr_i(instr_addr),
    .instr_rdata_o(p_ird), .instr_err_o(p_ierr),
    .data_req_i(data_req), .data_gnt_o(p_dg), .data_rvalid_o(p_drv), .data_we_i(data_we),
    .data_be_i(data_be), .data_addr_i(data_addr), .data_wdata_i(data_wdata),
    .data_rdata_o(p_drd), .data_err_o(p_derr),
    .mem_req_o(p_mreq), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_we_o(p_mwe),
    .mem_be_o(p_mbe), .mem_addr_o(p_maddr), .mem_wdata_o(p_mwd), .mem_rdata_i(mem_rdata),
    .mem_err_i(mem_err), .protocol_err_o(p_perr)
  );

  cve2_mem_arbiter #(.MaxOutstanding(2), .DataPriority(1'b0)) dut_r (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_gnt_o(r_ig), .instr_rvalid_o(r_irv), .instr_addr_i(instr_addr),
    .instr_rdata_o(r_ird), .instr_err_o(r_ierr),
    .data_req_i(data_req), .data_gnt_o(r_dg), .data_rvalid_o(r_drv), .data_we_i(data_we),
    .data_be_i(data_be), .data_addr_i(data_addr), .data_wdata_i(data_wdata),
    .data_rdata_o(r_drd), .data_err_o(r_derr),
    .mem_req_o(r_mreq), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_we_o(r_mwe),
    .mem_be_o(r_mbe), .mem_addr_o(r_maddr), .mem_wdata_o(r_mwd), .mem_rdata_i(mem_rdata),
    .mem_err_i(mem_err), .protocol_err_o(r_perr)
  );

  // observed outputs of whichever build is under test
  logic        o_ig, o_irv, o_ierr, o_dg, o_drv, o_derr, o_mreq, o_mwe, o_perr;
  logic [31:0] o_ird, o_drd, o_maddr, o_mwd;
  logic [3:0]  o_mbe;
  assign o_ig    = use_rr ? r_ig    : p_ig;
  assign o_irv   = use_rr ? r_irv   : p_irv;
  assign o_ierr  = use_rr ? r_ierr  : p_ierr;
  assign o_ird   = use_rr ? r_ird   : p_ird;
  assign o_dg    = use_rr ? r_dg    : p_dg;
  assign o_drv   = use_rr ? r_drv   : p_drv;
  assign o_derr  = use_rr ? r_derr  : p_derr;
  assign o_drd   = use_rr ? r_drd   : p_drd;
  assign o_mreq  = use_rr ? r_mreq  : p_mreq;
  assign o_mwe   = use_rr ? r_mwe   : p_mwe;
  assign o_mbe   = use_rr ? r_mbe   : p_mbe;
  assign o_maddr = use_rr ? r_maddr : p_maddr;
  assign o_mwd   = use_rr ? r_mwd   : p_mwd;
  assign o_perr  = use_rr ? r_perr  : p_perr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit ir, input bit dr, input bit g, input bit rv,
                      input logic [31:0] rd, input bit er);
    @(negedge clk);
    instr_req = ir; data_req = dr; mem_gnt = g; mem_rvalid = rv; mem_rdata = rd; mem_err = er;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; instr_req = 0; data_req = 0; mem_gnt = 0; mem_rvalid = 0; mem_err = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference: queue of outstanding sources, a locked pending source, and the last granted source.
  task automatic run_random(input bit rr, input int ncycles);
    int q_src[$];
    int pend = -1, last = 1, sel;
    bit i_hold = 0, d_hold = 0, ereq, eg, erv_i, erv_d;
    for (int c = 0; c < ncycles; c++) begin
      @(negedge clk);
      if (!i_hold) begin instr_req = 1'($urandom_range(0, 1)); instr_addr = $urandom & 32'hFFFF_FFFC; end
      if (!d_hold) begin
        data_req = 1'($urandom_range(0, 1)); data_addr = $urandom & 32'hFFFF_FFFC;
        data_we = 1'($urandom_range(0, 1)); data_be = 4'($urandom); data_wdata = $urandom;
      end
      mem_gnt    = ($urandom_range(0, 3) != 0);
      mem_rvalid = (q_src.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_rdata  = $urandom;
      mem_err    = 1'($urandom_range(0, 1));
      #1;
      if (pend >= 0) sel = pend;
      else if (instr_req && data_req) sel = rr ? ((last == 1) ? 0 : 1) : 1;
      else sel = data_req ? 1 : 0;
      ereq = (q_src.size() < 2) && ((sel == 1) ? data_req : instr_req);
      eg   = ereq && mem_gnt;
      chk("rnd_mem_req", 32'(o_mreq), 32'(ereq));
      if (ereq) begin
        chk("rnd_mem_addr", o_maddr, (sel == 1) ? data_addr : instr_addr);
        chk("rnd_mem_we", 32'(o_mwe), (sel == 1) ? 32'(data_we) : 32'd0);
        chk("rnd_mem_be", 32'(o_mbe), (sel == 1) ? 32'(data_be) : 32'hF);
        chk("rnd_mem_wdata", o_mwd, (sel == 1) ? data_wdata : 32'd0);
      end
      chk("rnd_instr_gnt", 32'(o_ig), 32'(eg && sel == 0));
      chk("rnd_data_gnt", 32'(o_dg), 32'(eg && sel == 1));
      erv_i = mem_rvalid && q_src.size() > 0 && q_src[0] == 0;
      erv_d = mem_rvalid && q_src.size() > 0 && q_src[0] == 1;
      chk("rnd_instr_rvalid", 32'(o_irv), 32'(erv_i));
      chk("rnd_data_rvalid", 32'(o_drv), 32'(erv_d));
      if (erv_i) begin chk("rnd_instr_rdata", o_ird, mem_rdata); chk("rnd_instr_err", 32'(o_ierr), 32'(mem_err)); end
      if (erv_d) begin chk("rnd_data_rdata", o_drd, mem_rdata); chk("rnd_data_err", 32'(o_derr), 32'(mem_err)); end
      chk("rnd_protocol_err", 32'(o_perr), 32'd0);
      if (mem_rvalid && q_src.size() > 0) void'(q_src.pop_front());
      if (eg) begin q_src.push_back(sel); last = sel; end
      pend   = (ereq && !mem_gnt) ? sel : -1;
      i_hold = instr_req && !(eg && sel == 0);
      d_hold = data_req && !(eg && sel == 1);
    end
    while (q_src.size() > 0) begin
      step(0, 0, 0, 1, $urandom, 0);
      chk("drain_instr_rvalid", 32'(o_irv), 32'(q_src[0] == 0));
      chk("drain_data_rvalid", 32'(o_drv), 32'(q_src[0] == 1));
      void'(q_src.pop_front());
    end
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    use_rr = 0; instr_req = 0; data_req = 0; data_we = 0; data_be = 0; mem_gnt = 0;
    mem_rvalid = 0; mem_err = 0; instr_addr = 0; data_addr = 0; data_wdata = 0; mem_rdata = 0;
    do_reset();

    // reset state
    step(0, 0, 1, 0, 0, 0);
    chk("rst_mem_req", 32'(o_mreq), 0);
    chk("rst_instr_gnt", 32'(o_ig), 0);
    chk("rst_data_gnt", 32'(o_dg), 0);
    chk("rst_protocol_err_p", 32'(p_perr), 0);
    chk("rst_protocol_err_r", 32'(r_perr), 0);

    // single instr read
    instr_addr = 32'h100;
    step(1, 0, 1, 0, 0, 0);
    chk("t1_instr_gnt", 32'(o_ig), 1);
    chk("t1_mem_addr", o_maddr, 32'h100);
    chk("t1_mem_be", 32'(o_mbe), 32'hF);
    chk("t1_mem_we", 32'(o_mwe), 0);
    step(0, 0, 0, 1, 32'hDEADBEEF, 0);
    chk("t1_instr_rvalid", 32'(o_irv), 1);
    chk("t1_instr_rdata", o_ird, 32'hDEADBEEF);
    chk("t1_data_rvalid", 32'(o_drv), 0);

    // simultaneous instr + data write, data wins
    instr_addr = 32'h200; data_addr = 32'h300; data_we = 1; data_be = 4'h3; data_wdata = 32'h1234_5678;
    step(1, 1, 1, 0, 0, 0);
    chk("t2_data_gnt", 32'(o_dg), 1);
    chk("t2_instr_gnt0", 32'(o_ig), 0);
    chk("t2_mem_we", 32'(o_mwe), 1);
    chk("t2_mem_be", 32'(o_mbe), 32'h3);
    chk("t2_mem_wdata", o_mwd, 32'h1234_5678);
    step(1, 0, 1, 0, 0, 0);
    chk("t2_instr_gnt", 32'(o_ig), 1);
    chk("t2_instr_addr", o_maddr, 32'h200);
    chk("t2_instr_wdata", o_mwd, 0);
    step(0, 0, 0, 1, 32'hAAAA_0001, 0);
    chk("t2_resp1_data", 32'(o_drv), 1);
    chk("t2_resp1_instr", 32'(o_irv), 0);
    step(0, 0, 0, 1, 32'hAAAA_0002, 0);
    chk("t2_resp2_instr", 32'(o_irv), 1);
    chk("t2_resp2_data", 32'(o_drv), 0);

    // data request held ungranted; later instr request must not steal the port
    data_we = 0; data_be = 4'hF; instr_addr = 32'h400;
    step(0, 1, 0, 0, 0, 0);
    chk("t3_c1_addr", o_maddr, 32'h300);
    chk("t3_c1_req", 32'(o_mreq), 1);
    for (int k = 2; k <= 3; k++) begin
      step(1, 1, 0, 0, 0, 0);
      chk("t3_hold_addr", o_maddr, 32'h300);
      chk("t3_hold_instr_gnt", 32'(o_ig), 0);
    end
    step(1, 1, 1, 0, 0, 0);
    chk("t3_data_gnt", 32'(o_dg), 1);
    chk("t3_data_gnt_instr", 32'(o_ig), 0);
    step(1, 0, 1, 0, 0, 0);
    chk("t3_instr_gnt", 32'(o_ig), 1);
    chk("t3_instr_addr", o_maddr, 32'h400);
    step(0, 0, 0, 1, 1, 0);
    chk("t3_resp_data", 32'(o_drv), 1);
    step(0, 0, 0, 1, 2, 0);
    chk("t3_resp_instr", 32'(o_irv), 1);

    // outstanding limit of 2
    step(1, 0, 1, 0, 0, 0); chk("t4_gnt1", 32'(o_ig), 1);
    step(1, 0, 1, 0, 0, 0); chk("t4_gnt2", 32'(o_ig), 1);
    step(1, 0, 1, 0, 0, 0); chk("t4_full_req", 32'(o_mreq), 0); chk("t4_full_gnt", 32'(o_ig), 0);
    step(1, 0, 1, 1, 5, 0); chk("t4_pop_req", 32'(o_mreq), 0); chk("t4_pop_rvalid", 32'(o_irv), 1);
    step(1, 0, 1, 0, 0, 0); chk("t4_third_req", 32'(o_mreq), 1); chk("t4_third_gnt", 32'(o_ig), 1);
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 0, 1, 6, 0); chk("t4_drain", 32'(o_irv), 1);
    end
    step(0, 0, 0, 0, 0, 0);

    // round-robin alternation with an error on the second response
    do_reset();
    use_rr = 1;
    for (int k = 0; k < 6; k++) begin
      step(1, 1, 1, k >= 1, 32'h100 + 32'(k), k == 2);
      chk("t5_instr_gnt", 32'(o_ig), 32'(k % 2 == 0));
      chk("t5_data_gnt", 32'(o_dg), 32'(k % 2 == 1));
      if (k >= 1) begin
        chk("t5_instr_rvalid", 32'(o_irv), 32'((k - 1) % 2 == 0));
        chk("t5_data_rvalid", 32'(o_drv), 32'((k - 1) % 2 == 1));
        chk("t5_data_err", 32'(o_derr && o_drv), 32'(k == 2));
        chk("t5_instr_err", 32'(o_ierr && o_irv), 0);
      end
    end
    step(0, 0, 0, 1, 0, 0);
    chk("t5_drain_data", 32'(o_drv), 1);
    step(0, 0, 0, 0, 0, 0);

    // spurious rvalid
    do_reset();
    use_rr = 0;
    step(0, 0, 0, 1, 32'h55, 0);
    chk("t6_no_irv", 32'(o_irv), 0);
    chk("t6_no_drv", 32'(o_drv), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t6_perr_set", 32'(o_perr), 1);
    step(0, 0, 0, 0, 0, 0);
    chk("t6_perr_sticky", 32'(o_perr), 1);
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    chk("t6_perr_cleared", 32'(o_perr), 0);

    // randomized against the reference model, both arbitration modes
    use_rr = 0;
    do_reset();
    run_random(1'b0, 400);
    use_rr = 1;
    do_reset();
    run_random(1'b1, 400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cve2_mem_arbiter.md
Name: cve2_mem_arbiter

Overview:
- Shares one OBI-style memory port (req/gnt/rvalid, in-order responses) between the core's instruction-fetch and data (LSU) interfaces.
- Sits between cve2_top and a single-ported memory or bus in cost-reduced integrations.
- Arbitrates address phases and locks a pending request until it is granted.
- Tracks the source of each outstanding transaction so responses are routed back in order.

Parameters:
- MaxOutstanding, 2, depth of the source-tracking FIFO; legal range 1..4.
- DataPriority, 1'b1: 1 = fixed priority, data over instr; 0 = round-robin, alternating after each grant.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- instr_req_i  in  1  instr request
- instr_gnt_o  out  1  instr grant
- instr_rvalid_o  out  1  instr response valid
- instr_addr_i  in  32  instr address
- instr_rdata_o  out  32  instr read data
- instr_err_o  out  1  instr bus error
- data_req_i  in  1  data request
- data_gnt_o  out  1  data grant
- data_rvalid_o  out  1  data response valid
- data_we_i  in  1  data write enable
- data_be_i  in  4  data byte enables
- data_addr_i  in  32  data address
- data_wdata_i  in  32  data write data
- data_rdata_o  out  32  data read data
- data_err_o  out  1  data bus error
- mem_req_o  out  1  memory request
- mem_gnt_i  in  1  memory grant
- mem_rvalid_i  in  1  memory response valid
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  memory byte enables
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data
- mem_err_i  in  1  memory error
- protocol_err_o  out  1  sticky flag: rvalid received with no outstanding transaction

Behaviour:
- Registered state:
  - lock_q (1b), lock_src_q (mem_src_e), rr_last_q (mem_src_e).
  - Source FIFO: MaxOutstanding entries of mem_src_e, plus count.
  - protocol_err_q.
  - Reset values: lock_q=0, rr_last_q=MemSrcData, FIFO empty, protocol_err_o=0.
- Issue enable: can_issue = (count < MaxOutstanding). No combinational path from mem_rvalid_i to mem_req_o; when full, issue waits one cycle after a pop.
- Source selection:
  - If lock_q=1: sel = lock_src_q.
  - Else, if both requesting: DataPriority=1 selects data; DataPriority=0 selects the source not equal to rr_last_q.
  - Else: whichever source is requesting.
- Request path:
  - mem_req_o = can_issue & (sel's req).
  - mem_we/be/addr/wdata are driven from sel.
  - When instr is selected: mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
- Grant path: grant goes only to sel: {instr,data}_gnt_o = mem_gnt_i & mem_req_o & (sel==src). The unselected source sees gnt=0.
- Lock:
  - Set when mem_req_o & ~mem_gnt_i, with lock_src_q=sel.
  - Cleared on mem_req_o & mem_gnt_i.
  - The address phase therefore never switches source while a memory request is pending.
  - Deassertion of the locked source's req is a requester protocol violation; the lock then clears next cycle with no grant.
- Handshake accounting:
  - On mem_req_o & mem_gnt_i: push sel; rr_last_q <= sel.
  - On mem_rvalid_i with count>0: pop the head and route the response.
  - Push and pop in the same cycle leave count unchanged.
  - Minimum latency is one cycle from grant to rvalid. Same-cycle rvalid for the entry being granted is illegal.
- Response routing:
  - {src}_rvalid_o = mem_rvalid_i & (count>0) & (head==src).
  - rdata and err are broadcast to both sides; they are only meaningful when that side's rvalid is set.
- Error flag: mem_rvalid_i with count==0 sets protocol_err_o (sticky until reset); the response is dropped.
- Reset mid-transaction: all state is cleared; outstanding responses arriving after reset set protocol_err_o.

Decomposition:
- cve2_pkg additions:
  - typedef enum logic {MemSrcInstr=1'b0, MemSrcData=1'b1} mem_src_e.
  - localparam MemArbMaxOutstanding=4.
- One sub-module, cve2_mem_arb_src_fifo:
  - Parameterised depth, storing mem_src_e.
  - push/pop/full/empty/head.
  - Same-cycle push+pop when non-empty.

Test Plan:
- Single instr read to 0x100, memory gnt same cycle, rdata 0xDEADBEEF after 1 cycle:
  - instr_gnt_o=1 in the request cycle.
  - instr_rvalid_o=1 with rdata 0xDEADBEEF.
  - data_rvalid_o stays 0.
- Simultaneous instr (0x200) and data write (0x300, be 4'h3), DataPriority=1:
  - Data granted first with mem_we_o=1, mem_be_o=3.
  - Instr granted the next cycle.
  - Responses routed data then instr.
- Data request held with mem_gnt_i=0 for 3 cycles while instr_req_i rises in cycle 2:
  - mem_addr_o stays 0x300 throughout.
  - instr_gnt_o=0 until after the data grant.
- MaxOutstanding=2, three back-to-back instr requests, rvalid withheld:
  - 2 grants, then mem_req_o=0.
  - After the first rvalid, the third request issues the next cycle.
- DataPriority=0, both requesting continuously, immediate grants: grants alternate instr/data (starting instr after reset); responses are routed correctly with mem_err_i=1 on the 2nd response → data_err_o=1 only there.
- mem_rvalid_i pulse with no outstanding transaction: protocol_err_o=1 and stays set; no rvalid on either side; cleared by rst_ni=0.
